// File: rtl/serial_deser.sv
// serial_deser: serial-to-parallel stage behind the parallel-to-serial shifter.
// Rebuilds BITS-wide words from ser_in/eos_in and presents them on a one-entry
// valid/ready buffer, flagging framing errors and overruns (sticky).
// Optional feature macro: DESER_LSB_FIRST_EN (LSB-first bit order; default MSB first).
module serial_deser #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            ser_in,
   input  logic            eos_in,
   output logic [BITS-1:0] data_out,
   output logic            data_valid,
   input  logic            data_ready,
   output logic            frame_err,
   output logic            overrun,
   input  logic            clear_flags
);

   localparam int CW = $clog2(BITS);
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   typedef enum logic {
      SYNC,
      RECV
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [BITS-1:0] shreg_q, shreg_d;
   logic [BITS-1:0] data_out_q, data_out_d;
   logic            data_valid_q, data_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;

   logic [BITS-1:0] word_next;
   logic            word_done;
   logic            fe_set;
   logic            ov_set;

   // Shift register contents including the bit sampled this cycle
`ifdef DESER_LSB_FIRST_EN
   assign word_next = {ser_in, shreg_q[BITS-1:1]};
`else
   assign word_next = {shreg_q[BITS-2:0], ser_in};
`endif

   // Framing FSM, output buffer and sticky flag next-state logic
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      word_done    = 1'b0;
      fe_set       = 1'b0;
      ov_set       = 1'b0;

      if (ena) begin
         shreg_d = word_next;
         unique case (state_q)
            SYNC: begin
               if (eos_in) begin
                  state_d   = RECV;
                  bit_cnt_d = '0;
               end
            end
            RECV: begin
               if (bit_cnt_q == LAST) begin
                  bit_cnt_d = '0;
                  if (eos_in) begin
                     word_done = 1'b1;
                  end else begin
                     fe_set  = 1'b1;
                     state_d = SYNC;
                  end
               end else if (eos_in) begin
                  // early eos: drop the partial word and realign on it
                  fe_set    = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            default: state_d = SYNC;
         endcase
      end

      // a completing word may replace one being drained on the same edge
      if (word_done) begin
         if (!data_valid_q || data_ready) begin
            data_out_d   = word_next;
            data_valid_d = 1'b1;
         end else begin
            ov_set = 1'b1;
         end
      end else if (data_valid_q && data_ready) begin
         data_valid_d = 1'b0;
      end

      frame_err_d = fe_set | (frame_err_q & ~clear_flags);
      overrun_d   = ov_set | (overrun_q & ~clear_flags);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SYNC;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser (BITS=8): table of back-to-back words
// followed by hand-written sequences for sync loss, ena gaps, reset and flags.
module tb_serial_deser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       ser_in;
   logic       eos_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       clear_flags;

   int n_checks = 0;
   int n_fail   = 0;

   serial_deser #(.BITS(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .ser_in      (ser_in),
      .eos_in      (eos_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .clear_flags (clear_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] word;
      int         eos_idx;
      logic       rdy;
      logic       rdy_last;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_fe;
      logic       exp_ov;
   } vec_t;

   vec_t vecs[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] d, input logic v,
                          input logic fe, input logic ov);
      chk({tag, ".data_out"}, data_out, d);
      chk({tag, ".data_valid"}, {7'd0, data_valid}, {7'd0, v});
      chk({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, fe});
      chk({tag, ".overrun"}, {7'd0, overrun}, {7'd0, ov});
   endtask

   // Sends stream bits first..last of word w. In raw mode w[7] goes first
   // regardless of build; otherwise the order matches the configured bit order.
   task automatic send_range(input logic [7:0] w, input int first, input int last,
                             input int eos_idx, input logic rdy, input logic rdy_last,
                             input bit raw);
      for (int i = first; i <= last; i++) begin
`ifdef DESER_LSB_FIRST_EN
         ser_in = raw ? w[7 - i] : w[i];
`else
         ser_in = w[7 - i];
`endif
         eos_in     = (i == eos_idx);
         data_ready = (i == last) ? rdy_last : rdy;
         step();
      end
      ser_in = 1'b0;
      eos_in = 1'b0;
   endtask

   initial begin
      // word, eos_idx, rdy, rdy_last, exp_data, exp_valid, exp_fe, exp_ov
      vecs[0] = '{8'hA5, 7, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 7, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h11, 7, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h22, 7, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{8'h33, 7, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{8'h55, 4, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1};
      vecs[6] = '{8'h3C, 7, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1};

      rst_n = 1'b0; ena = 1'b0; ser_in = 1'b0; eos_in = 1'b0;
      data_ready = 1'b0; clear_flags = 1'b0;
      step(); step();
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();

      // bits without any eos stay in SYNC
      ena = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ser_in = 1'b1;
         step();
      end
      ser_in = 1'b0;
      chk_all("no_sync", 8'h00, 1'b0, 1'b0, 1'b0);

      // sync eos
      eos_in = 1'b1;
      step();
      eos_in = 1'b0;

      for (int v = 0; v < 7; v++) begin
         int last;
         last = (vecs[v].eos_idx >= 0) ? vecs[v].eos_idx : 7;
         send_range(vecs[v].word, 0, last, vecs[v].eos_idx, vecs[v].rdy,
                    vecs[v].rdy_last, 1'b0);
         chk_all($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_valid,
                 vecs[v].exp_fe, vecs[v].exp_ov);
      end

      // valid lasts one cycle when ready; handshake works with ena=0
      ena = 1'b0; data_ready = 1'b1;
      step();
      chk_all("drain", 8'h3C, 1'b0, 1'b1, 1'b1);

      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      chk_all("clear", 8'h3C, 1'b0, 1'b0, 1'b0);
      ena = 1'b1;

      // 8 bits with no eos: frame error and loss of sync
      send_range(8'h77, 0, 7, -1, 1'b1, 1'b1, 1'b0);
      chk_all("no_eos", 8'h3C, 1'b0, 1'b1, 1'b0);
      send_range(8'h99, 0, 7, 7, 1'b1, 1'b1, 1'b0);
      chk_all("resync_drop", 8'h3C, 1'b0, 1'b1, 1'b0);
      send_range(8'h5A, 0, 7, 7, 1'b1, 1'b1, 1'b0);
      chk_all("resync_word", 8'h5A, 1'b1, 1'b1, 1'b0);

      // ena gap mid-word with junk on the inputs
      ena = 1'b0; clear_flags = 1'b1; data_ready = 1'b1;
      step();
      clear_flags = 1'b0; ena = 1'b1;
      chk_all("clear2", 8'h5A, 1'b0, 1'b0, 1'b0);
      send_range(8'hC3, 0, 3, -1, 1'b1, 1'b1, 1'b0);
      ena = 1'b0; ser_in = 1'b1; eos_in = 1'b1;
      step(); step(); step();
      ena = 1'b1; ser_in = 1'b0; eos_in = 1'b0;
      send_range(8'hC3, 4, 7, 7, 1'b1, 1'b1, 1'b0);
      chk_all("ena_gap", 8'hC3, 1'b1, 1'b0, 1'b0);

      // reset mid-word discards the partial word and returns to SYNC
      send_range(8'h81, 0, 3, -1, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      send_range(8'h81, 4, 7, 7, 1'b1, 1'b1, 1'b0);
      chk_all("post_reset_sync", 8'h00, 1'b0, 1'b0, 1'b0);
      send_range(8'h42, 0, 7, 7, 1'b1, 1'b1, 1'b0);
      chk_all("post_reset_word", 8'h42, 1'b1, 1'b0, 1'b0);

      // flag set wins over clear_flags in the same cycle
      clear_flags = 1'b1;
      send_range(8'h24, 0, 2, 2, 1'b1, 1'b1, 1'b0);
      clear_flags = 1'b0;
      chk_all("set_priority", 8'h42, 1'b0, 1'b1, 1'b0);

      // raw stream 1,0,1,0,0,0,0,0 + eos: bit order depends on build
`ifdef DESER_LSB_FIRST_EN
      send_range(8'hA0, 0, 7, 7, 1'b1, 1'b1, 1'b1);
      chk_all("bit_order", 8'h05, 1'b1, 1'b1, 1'b0);
`else
      send_range(8'hA0, 0, 7, 7, 1'b1, 1'b1, 1'b1);
      chk_all("bit_order", 8'hA0, 1'b1, 1'b1, 1'b0);
`endif

      clear_flags = 1'b1; ena = 1'b0;
      step();
      clear_flags = 1'b0;
      chk_all("final_clear", data_out_exp(), 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   function automatic logic [7:0] data_out_exp();
`ifdef DESER_LSB_FIRST_EN
      return 8'h05;
`else
      return 8'hA0;
`endif
   endfunction

endmodule
